// File: rtl/npu_pkg.sv
// Shared definitions for the NPU command sequencer: opcodes, FSM states,
// status bit positions and the default result width.
package npu_pkg;

    localparam logic [7:0] OP_WR_WGT     = 8'h01;
    localparam logic [7:0] OP_WR_ACT     = 8'h02;
    localparam logic [7:0] OP_RUN        = 8'h10;
    localparam logic [7:0] OP_RD_RES     = 8'h20;
    localparam logic [7:0] OP_RD_STATUS  = 8'h30;
    localparam logic [7:0] OP_CLR_STATUS = 8'h3F;

    localparam int RES_W_DEF = 16;

    localparam int ST_TIMEOUT  = 15;
    localparam int ST_ILLEGAL  = 14;
    localparam int ST_ZERO_LEN = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RUN_START,
        S_RUN_WAIT,
        S_READ_REQ,
        S_READ_CAP,
        S_RESP
    } seq_state_e;

endpackage

// File: rtl/npu_run_watchdog.sv
// Cycle counter for a MAC run: held clear outside the wait window, counts while
// enabled and flags the last permitted cycle of the window.
module npu_run_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the final wait cycle so the abort lands one cycle later.
    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/npu_cmd_sequencer.sv
// Host frame decoder and NPU run sequencer: buffer writes, supervised MAC runs,
// result/status readback into the MISO response register.
module npu_cmd_sequencer
    import npu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int VAL_W       = 8,
    parameter int RES_W       = RES_W_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [7:0]        frame_cmd,
    input  logic [15:0]       frame_data,
    output logic              frame_ready,
    output logic              wgt_we,
    output logic              act_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [VAL_W-1:0]  buf_wdata,
    output logic              mac_start,
    output logic [7:0]        mac_len,
    input  logic              mac_done,
    output logic              mac_abort,
    output logic              res_re,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [RES_W-1:0]  res_rdata,
    output logic [RES_W-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ack,
    output logic              done,
    output logic [15:0]       status
);

    seq_state_e state, state_next;

    logic             accept;
    logic             wd_expire;
    logic             flag_to, flag_ill, flag_zl;
    logic [7:0]       run_cnt;

    logic             wgt_we_n, act_we_n, mac_start_n, mac_abort_n, res_re_n;
    logic             done_n, ready_n, tx_valid_n;
    logic             flag_to_n, flag_ill_n, flag_zl_n;
    logic [7:0]       run_cnt_n, mac_len_n;
    logic [RES_W-1:0] tx_data_n;

    assign accept = frame_valid && frame_ready;

    npu_run_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_RUN_WAIT),
        .enable (state == S_RUN_WAIT),
        .expire (wd_expire)
    );

    always_comb begin
        status              = '0;
        status[ST_TIMEOUT]  = flag_to;
        status[ST_ILLEGAL]  = flag_ill;
        status[ST_ZERO_LEN] = flag_zl;
        status[7:0]         = run_cnt;
    end

    always_comb begin
        state_next  = state;
        wgt_we_n    = 1'b0;
        act_we_n    = 1'b0;
        mac_start_n = 1'b0;
        mac_abort_n = 1'b0;
        res_re_n    = 1'b0;
        mac_len_n   = mac_len;
        flag_to_n   = flag_to;
        flag_ill_n  = flag_ill;
        flag_zl_n   = flag_zl;
        run_cnt_n   = run_cnt;
        tx_data_n   = tx_data;
        tx_valid_n  = tx_valid && !tx_ack;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    // Single-cycle commands act at acceptance and pass through
                    // WRITE with no strobe, so every frame ends in RESP.
                    case (frame_cmd)
                        OP_WR_WGT: begin
                            wgt_we_n   = 1'b1;
                            state_next = S_WRITE;
                        end
                        OP_WR_ACT: begin
                            act_we_n   = 1'b1;
                            state_next = S_WRITE;
                        end
                        OP_RUN: begin
                            if (frame_data[7:0] == 8'd0) begin
                                flag_zl_n  = 1'b1;
                                state_next = S_RESP;
                            end else begin
                                mac_start_n = 1'b1;
                                mac_len_n   = frame_data[7:0];
                                state_next  = S_RUN_START;
                            end
                        end
                        OP_RD_RES: begin
                            res_re_n   = 1'b1;
                            state_next = S_READ_REQ;
                        end
                        OP_RD_STATUS: begin
                            tx_data_n  = RES_W'(status);
                            tx_valid_n = 1'b1;
                            state_next = S_WRITE;
                        end
                        OP_CLR_STATUS: begin
                            flag_to_n  = 1'b0;
                            flag_ill_n = 1'b0;
                            flag_zl_n  = 1'b0;
                            run_cnt_n  = 8'd0;
                            state_next = S_WRITE;
                        end
                        default: begin
                            flag_ill_n = 1'b1;
                            state_next = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE:     state_next = S_RESP;
            S_RUN_START: state_next = S_RUN_WAIT;
            S_RUN_WAIT: begin
                // Completion wins over a coincident expiry.
                if (mac_done) begin
                    run_cnt_n  = run_cnt + 8'd1;
                    state_next = S_RESP;
                end else if (wd_expire) begin
                    mac_abort_n = 1'b1;
                    flag_to_n   = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_READ_REQ:  state_next = S_READ_CAP;
            S_READ_CAP: begin
                tx_data_n  = res_rdata;
                tx_valid_n = 1'b1;
                state_next = S_RESP;
            end
            S_RESP:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase

        done_n  = (state_next == S_RESP);
        ready_n = (state_next == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            frame_ready <= 1'b1;
            wgt_we      <= 1'b0;
            act_we      <= 1'b0;
            mac_start   <= 1'b0;
            mac_abort   <= 1'b0;
            res_re      <= 1'b0;
            done        <= 1'b0;
            mac_len     <= 8'd0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            flag_to     <= 1'b0;
            flag_ill    <= 1'b0;
            flag_zl     <= 1'b0;
            run_cnt     <= 8'd0;
        end else begin
            state       <= state_next;
            frame_ready <= ready_n;
            wgt_we      <= wgt_we_n;
            act_we      <= act_we_n;
            mac_start   <= mac_start_n;
            mac_abort   <= mac_abort_n;
            res_re      <= res_re_n;
            done        <= done_n;
            mac_len     <= mac_len_n;
            tx_data     <= tx_data_n;
            tx_valid    <= tx_valid_n;
            flag_to     <= flag_to_n;
            flag_ill    <= flag_ill_n;
            flag_zl     <= flag_zl_n;
            run_cnt     <= run_cnt_n;
        end
    end

    // Operand registers only qualify strobes, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_addr  <= frame_data[15 -: ADDR_W];
            buf_wdata <= frame_data[VAL_W-1:0];
            res_addr  <= frame_data[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_npu_cmd_sequencer.sv
// Randomized frame-level bench for npu_cmd_sequencer with a transaction-level
// reference model of latencies, strobes, status and the response register.
module tb_npu_cmd_sequencer;

    localparam int TB_TIMEOUT = 4096;
    localparam int BUDGET     = TB_TIMEOUT + 64;

    logic        clk, rst;
    logic        frame_valid, frame_ready;
    logic [7:0]  frame_cmd;
    logic [15:0] frame_data;
    logic        wgt_we, act_we, mac_start, mac_done, mac_abort, res_re;
    logic [7:0]  buf_addr, buf_wdata, mac_len, res_addr;
    logic [15:0] res_rdata, tx_data, status;
    logic        tx_valid, tx_ack, done;

    logic [15:0] mem [256];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_to, m_ill, m_zl, m_runs, m_txv;
    logic [15:0] m_tx;

    npu_cmd_sequencer #(
        .ADDR_W(8), .VAL_W(8), .RES_W(16), .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_data(frame_data),
        .frame_ready(frame_ready),
        .wgt_we(wgt_we), .act_we(act_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .mac_start(mac_start), .mac_len(mac_len), .mac_done(mac_done), .mac_abort(mac_abort),
        .res_re(res_re), .res_addr(res_addr), .res_rdata(res_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
        .done(done), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_re) res_rdata <= mem[res_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_status();
        return (m_to << 15) | (m_ill << 14) | (m_zl << 13) | m_runs;
    endfunction

    task automatic model_reset();
        m_to = 0; m_ill = 0; m_zl = 0; m_runs = 0; m_txv = 0; m_tx = 16'h0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ready"},  frame_ready, 1);
        chk({pfx, "_strobe"}, {wgt_we, act_we, mac_start, mac_abort, res_re, done}, 0);
        chk({pfx, "_txv"},    tx_valid, 0);
        chk({pfx, "_txd"},    tx_data, 0);
        chk({pfx, "_status"}, status, 0);
        chk({pfx, "_len"},    mac_len, 0);
    endtask

    // d: cycles from observed mac_start to mac_done pulse (<=0: never).
    // ack_k: frame-relative cycle in which tx_ack is held high (-1: none).
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] data,
                              input int d, input int ack_k);
        int n, k, done_k, wgt_k, act_k, start_k, abort_k, re_k;
        int n_wgt, n_act, n_start, n_abort, len_bad;
        int e_done, e_wgt, e_act, e_start, e_abort, e_re;
        logic [7:0] wgt_a, wgt_d, act_a, act_d, re_a, len_seen;

        n = 0;
        while (frame_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (frame_ready !== 1'b1) chk("ready_wait", frame_ready, 1);

        frame_valid = 1'b1; frame_cmd = cmd; frame_data = data;
        tx_ack = (ack_k == 0); mac_done = 1'b0;
        k = 0; done_k = -1; wgt_k = -1; act_k = -1; start_k = -1; abort_k = -1; re_k = -1;
        n_wgt = 0; n_act = 0; n_start = 0; n_abort = 0; len_bad = 0;
        wgt_a = 0; wgt_d = 0; act_a = 0; act_d = 0; re_a = 0; len_seen = 0;

        while (done_k < 0 && k < BUDGET) begin
            @(negedge clk);
            k++;
            frame_valid = 1'b0;
            if (wgt_we) begin n_wgt++; if (wgt_k < 0) begin wgt_k = k; wgt_a = buf_addr; wgt_d = buf_wdata; end end
            if (act_we) begin n_act++; if (act_k < 0) begin act_k = k; act_a = buf_addr; act_d = buf_wdata; end end
            if (mac_start) begin n_start++; if (start_k < 0) begin start_k = k; len_seen = mac_len; end end
            if (start_k >= 0 && mac_len !== len_seen) len_bad++;
            if (mac_abort) begin n_abort++; if (abort_k < 0) abort_k = k; end
            if (res_re && re_k < 0) begin re_k = k; re_a = res_addr; end
            if (done) done_k = k;
            tx_ack = (k == ack_k);
            mac_done = (start_k >= 0 && d > 0 && k == start_k + d);
        end

        // Expected behaviour from the frame rules
        e_done = 2; e_wgt = -1; e_act = -1; e_start = 0; e_abort = -1; e_re = -1;
        if (ack_k >= 0) m_txv = 0;
        case (cmd)
            8'h01: e_wgt = 1;
            8'h02: e_act = 1;
            8'h10: begin
                if (data[7:0] == 8'd0) begin
                    e_done = 1; m_zl = 1;
                end else begin
                    e_start = 1;
                    if (d > 0 && d <= TB_TIMEOUT) begin
                        e_done = 2 + d; m_runs = (m_runs + 1) % 256;
                    end else begin
                        e_done = 2 + TB_TIMEOUT; e_abort = 2 + TB_TIMEOUT; m_to = 1;
                    end
                end
            end
            8'h20: begin e_done = 3; e_re = 1; m_tx = mem[data[7:0]]; m_txv = 1; end
            8'h30: begin m_tx = 16'(m_status()); m_txv = 1; end
            8'h3F: begin m_to = 0; m_ill = 0; m_zl = 0; m_runs = 0; end
            default: m_ill = 1;
        endcase

        chk("done_cycle", done_k, e_done);
        chk("wgt_cycle", wgt_k, e_wgt);
        chk("act_cycle", act_k, e_act);
        chk("we_count", n_wgt + n_act, (e_wgt > 0 || e_act > 0) ? 1 : 0);
        chk("start_count", n_start, e_start);
        chk("abort_cycle", abort_k, e_abort);
        chk("abort_count", n_abort, (e_abort > 0) ? 1 : 0);
        chk("re_cycle", re_k, e_re);
        if (e_wgt > 0) begin chk("wgt_addr", wgt_a, data[15:8]); chk("wgt_data", wgt_d, data[7:0]); end
        if (e_act > 0) begin chk("act_addr", act_a, data[15:8]); chk("act_data", act_d, data[7:0]); end
        if (e_start > 0) begin chk("mac_len", len_seen, data[7:0]); chk("len_stable", len_bad, 0); end
        if (e_re > 0) chk("res_addr", re_a, data[7:0]);

        @(negedge clk);
        tx_ack = 1'b0; mac_done = 1'b0;
        chk("ready_after", frame_ready, 1);
        chk("done_pulse", done, 0);
        chk("status", status, m_status());
        chk("tx_valid", tx_valid, m_txv);
        chk("tx_data", tx_data, m_tx);
    endtask

    task automatic ack_tx();
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        m_txv = 0;
        chk("ack_valid", tx_valid, 0);
        chk("ack_data", tx_data, m_tx);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [15:0] data;
        int d, ack_k, sel, aborts;

        rst = 1'b1; frame_valid = 1'b0; frame_cmd = 8'h0; frame_data = 16'h0;
        mac_done = 1'b0; tx_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[7] = 16'hBEEF;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        send_frame(8'h01, 16'hA53C, 0, -1);
        send_frame(8'h02, 16'h1277, 0, -1);
        send_frame(8'h10, 16'h0004, 10, -1);
        send_frame(8'h10, 16'h0004, 0, -1);
        send_frame(8'h10, 16'h0003, TB_TIMEOUT, -1);
        send_frame(8'h20, 16'h0007, 0, -1);
        ack_tx();
        send_frame(8'h20, 16'h0007, 0, 2);
        send_frame(8'hFF, 16'h0000, 0, -1);
        send_frame(8'h30, 16'h0000, 0, 0);
        chk("status_ill_bit", tx_data[14], 1);
        send_frame(8'h3F, 16'h0000, 0, -1);
        send_frame(8'h10, 16'h0000, 0, -1);

        // Completion pulse while idle must not count as a run
        mac_done = 1'b1;
        @(negedge clk);
        mac_done = 1'b0;
        send_frame(8'h30, 16'h0000, 0, -1);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 7);
            data = 16'($urandom);
            d = 0;
            case (sel)
                0: cmd = 8'h01;
                1: cmd = 8'h02;
                2: begin
                    cmd = 8'h10;
                    d = $urandom_range(1, 30);
                    if ($urandom_range(0, 7) == 0) data[7:0] = 8'h00;
                end
                3: cmd = 8'h20;
                4: cmd = 8'h30;
                5: cmd = 8'h3F;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h10 ||
                           cmd == 8'h20 || cmd == 8'h30 || cmd == 8'h3F)
                        cmd = 8'($urandom);
                end
            endcase
            ack_k = -1;
            if ($urandom_range(0, 2) == 0)
                ack_k = (cmd == 8'h20) ? 2 : (cmd == 8'h30) ? 0 : 1;
            send_frame(cmd, data, d, ack_k);
        end

        // Reset in the middle of a run
        frame_valid = 1'b1; frame_cmd = 8'h10; frame_data = 16'h0005;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_reset_outputs("rst_mid");
        aborts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mac_abort || mac_start || done) aborts++;
        end
        chk("rst_mid_quiet", aborts, 0);
        send_frame(8'h30, 16'h0000, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
